// File: rtl/module_registro_pipeline_hs.sv
`default_nettype none
// ============================================================================
// Module      : module_registro_pipeline_hs
// Description : Chain of DEPTH valid/ready register stages with backpressure,
//               bubble collapsing, synchronous flush and an occupancy count.
//               The last stage drives dato_o/valid_o straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module module_registro_pipeline_hs #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           dato_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           dato_o,
  output logic [$clog2(DEPTH+1)-1:0] ocupacion_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] dato_q [DEPTH];
  logic [WIDTH-1:0] dato_d [DEPTH];
  logic [OCC_W-1:0] ocup_q, ocup_d;

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] in_valid;
  logic [WIDTH-1:0] in_dato [DEPTH];

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + OCC_W'(v[k]);
    end
    return cnt;
  endfunction

  // Advance chain: a stage may move when it, or any stage downstream of it,
  // is empty, or when the consumer takes the head. Unrolled as a running OR
  // so the vector never feeds back on itself.
  always_comb begin : p_adv
    logic acc;
    adv = '0;
    acc = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc || !valid_q[k];
      adv[k] = acc;
    end
  end

  assign ready_o = adv[0] && !flush_i;

  // Stage inputs: stage 0 takes the upstream port, later stages their predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage_in
    if (k == 0) begin : g_head
      assign in_valid[k] = valid_i && ready_o;
      assign in_dato[k]  = dato_i;
    end else begin : g_body
      assign in_valid[k] = valid_q[k-1];
      assign in_dato[k]  = dato_q[k-1];
    end
  end

  // Next-state: flush clears valid bits only; data loads solely on a valid beat.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      dato_d[k] = dato_q[k];
    end
    if (flush_i) begin
      valid_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          valid_d[k] = in_valid[k];
          if (in_valid[k]) begin
            dato_d[k] = in_dato[k];
          end
        end
      end
    end
    ocup_d = popcount(valid_d);
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      ocup_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dato_q[k] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      ocup_q  <= ocup_d;
      for (int k = 0; k < DEPTH; k++) begin
        dato_q[k] <= dato_d[k];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign dato_o      = dato_q[DEPTH-1];
  assign ocupacion_o = ocup_q;

endmodule
`default_nettype wire

// File: doc/module_registro_pipeline_hs.md
Name: module_registro_pipeline_hs

Overview:
Parametrised chain of DEPTH enable-registers forming a pipeline. Each stage carries a WIDTH-bit dato and a valid bit. Upstream and downstream use a valid/ready handshake, with backpressure and bubble collapsing. Used between multicycle-processor stages (fetch→decode, ALU→writeback) wherever a plain enable register cannot absorb stalls. Adds a synchronous flush and an occupancy count.

Parameters:
WIDTH, 8, data bits per stage
DEPTH, 2, number of register stages; legal range 1..16
RESET_VAL, 0, value of every dato register after reset

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_i  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous flush; invalidates every stage
valid_i  input  1  upstream dato_i is valid
ready_o  output  1  pipeline accepts dato_i this cycle
dato_i  input  WIDTH  upstream data
valid_o  output  1  last stage holds valid data
ready_i  input  1  downstream accepts dato_o this cycle
dato_o  output  WIDTH  last stage data
ocupacion_o  output  $clog2(DEPTH+1)  count of valid stages, 0..DEPTH

Behaviour:
- Stage 0 is the input side; stage DEPTH-1 drives dato_o/valid_o directly (registered outputs, no combinational data path).
- Reset (rst_i=0, asynchronous): all valid bits=0; all dato registers=RESET_VAL.
  - Outputs during and after reset: valid_o=0, dato_o=RESET_VAL, ocupacion_o=0, ready_o=1 (unless flush_i=1).
  - Reset mid-transfer drops all in-flight data; no partial beat is preserved.
- Transfers: an input transfer occurs when valid_i && ready_o; an output transfer occurs when valid_o && ready_i.
- Per-stage advance, for k = DEPTH-1 down to 0:
  - adv[DEPTH-1] = !v[DEPTH-1] || ready_i
  - adv[k] = !v[k] || adv[k+1]
  - ready_o = adv[0] && !flush_i
  - The ready chain is combinational from ready_i; there are no registered bubbles.
- Stage update on each clock edge when flush_i=0:
  - If adv[k]: stage k loads from stage k-1 (dato and valid). Stage 0 loads dato_i with valid = valid_i && ready_o.
  - Else: stage k holds.
  - A dato register loads only when the incoming valid is 1. A dato register that receives an invalid beat keeps its old value.
- Latency: an accepted beat appears on valid_o exactly DEPTH cycles after its input transfer when no stall occurs. Throughput is one beat per cycle sustained.
- Hold rule: while valid_o=1 and ready_i=0, dato_o and valid_o stay stable until the output transfer.
- Bubble collapse: an empty stage ahead of a stalled stage still accepts. With valid_o=1 and ready_i=0, inputs are accepted until ocupacion_o=DEPTH. Full means ready_o = ready_i.
- Full and simultaneous events: when ocupacion_o=DEPTH and ready_i=1, an input transfer and an output transfer occur in the same cycle and occupancy stays DEPTH.
- Flush (flush_i=1, synchronous):
  - Next edge: all valid bits=0 and ocupacion_o=0. dato registers keep their values (not reset).
  - ready_o=0 during the flush cycle, so no input beat is accepted.
  - valid_o and ready_i may still complete an output transfer in that cycle; the stage is cleared anyway.
  - Flush has priority over every transfer-related state update.
- ocupacion_o is registered-equivalent: it is the population count of the valid bits, updated on the same edge as those bits. Width is $clog2(DEPTH+1); DEPTH=1 gives 1 bit.
- DEPTH=1 degenerates to a single enable register with handshake: ready_o = !valid_o || ready_i.
- No X propagation: dato_o never shows X after reset, even before the first beat.

Test Plan:
1. WIDTH=8, DEPTH=3. Release reset, hold ready_i=1, send 0x11,0x22,0x33 on consecutive cycles → valid_o rises 3 cycles after the first accept; dato_o = 0x11,0x22,0x33 on consecutive cycles; ocupacion_o peaks at 3.
2. DEPTH=3, ready_i=0. Stream 0xA0..0xA4 with valid_i=1 → exactly 3 accepted (0xA0..0xA2); ready_o=0 afterwards; dato_o held at 0xA0; ocupacion_o=3. Raise ready_i → 0xA0,0xA1,0xA2,0xA3,0xA4 delivered in order with no loss or duplication.
3. Full pipeline, valid_i=1 and ready_i=1 for 10 cycles → one beat in and one out every cycle; ocupacion_o constant at 3.
4. Two beats in flight, assert flush_i for one cycle with valid_i=1 → the input beat is not accepted (ready_o=0); next cycle valid_o=0 and ocupacion_o=0; dato_o retains its last value.
5. Drive rst_i low asynchronously mid-stream, between clock edges → valid_o=0, ocupacion_o=0 and dato_o=RESET_VAL immediately, without waiting for a clock edge. After release, the first new beat 0x5A appears after 3 cycles.
6. DEPTH=1, toggle ready_i randomly for 200 beats against a scoreboard → in-order, lossless delivery; latency 1 cycle when unstalled; dato_o stable whenever valid_o=1 and ready_i=0.
